// File: rtl/sp_mem_arbiter_pkg.sv
// Shared types and defaults for the single-port memory arbiter.
package sp_mem_arbiter_pkg;

    localparam int DEPTH_DEF      = 4096;
    localparam int STARVE_LIM_DEF = 4;

    localparam logic [0:0] ST_INIT = 1'b0;
    localparam logic [0:0] ST_RUN  = 1'b1;

    typedef enum logic [1:0] {
        OWN_NONE = 2'd0,
        OWN_IF   = 2'd1,
        OWN_D    = 2'd2
    } owner_t;

    // Word aligned and inside the array.
    function automatic logic addr_ok(input logic [31:0] addr, input int depth);
        return (addr[1:0] == 2'b00) && ({2'b00, addr[31:2]} < 32'(depth));
    endfunction

endpackage

// File: rtl/sp_mem_arbiter_if.sv
// Core-side request/response ports and memory-macro ports of the arbiter.
interface sp_mem_arbiter_if #(
    parameter int AW = 12
);
    logic          ready;
    logic          if_req;
    logic [31:0]   if_addr;
    logic          if_gnt;
    logic          if_rvalid;
    logic [31:0]   if_rdata;
    logic          d_req;
    logic          d_we;
    logic [31:0]   d_addr;
    logic [31:0]   d_wdata;
    logic          d_gnt;
    logic          d_rvalid;
    logic [31:0]   d_rdata;
    logic          err;
    logic          mem_en;
    logic          mem_we;
    logic [AW-1:0] mem_addr;
    logic [31:0]   mem_wdata;
    logic [31:0]   mem_rdata;

    modport master (
        output if_req, if_addr, d_req, d_we, d_addr, d_wdata, mem_rdata,
        input  ready, if_gnt, if_rvalid, if_rdata, d_gnt, d_rvalid, d_rdata,
               err, mem_en, mem_we, mem_addr, mem_wdata
    );

    modport slave (
        input  if_req, if_addr, d_req, d_we, d_addr, d_wdata, mem_rdata,
        output ready, if_gnt, if_rvalid, if_rdata, d_gnt, d_rvalid, d_rdata,
               err, mem_en, mem_we, mem_addr, mem_wdata
    );

endinterface

// File: rtl/sp_arb_prio.sv
// Data-first grant logic with a starvation guard that lets fetch win after
// STARVE_LIM consecutive denials.
module sp_arb_prio #(
    parameter int STARVE_LIM = 4
) (
    input  logic clk,
    input  logic rst_n,
    input  logic i_en,
    input  logic i_if_req,
    input  logic i_d_req,
    output logic o_if_gnt,
    output logic o_d_gnt
);

    localparam int CW = $clog2(STARVE_LIM + 1);

    logic [CW-1:0] r_starve_cnt;
    logic          w_fetch_first;
    logic          w_if_gnt;
    logic          w_d_gnt;

    assign w_fetch_first = i_if_req && (r_starve_cnt == CW'(STARVE_LIM));
    assign w_d_gnt       = i_en && i_d_req && !w_fetch_first;
    assign w_if_gnt      = i_en && i_if_req && !w_d_gnt;
    assign o_if_gnt      = w_if_gnt;
    assign o_d_gnt       = w_d_gnt;

    // Counter only tracks denials while arbitration is live.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_starve_cnt <= '0;
        end else if (i_en) begin
            if (!i_if_req || w_if_gnt) begin
                r_starve_cnt <= '0;
            end else if (r_starve_cnt != CW'(STARVE_LIM)) begin
                r_starve_cnt <= r_starve_cnt + 1'b1;
            end
        end
    end

endmodule

// File: rtl/sp_mem_arbiter.sv
// Shares one single-port memory between fetch and load/store ports, with an
// optional zero-clear sweep after reset.
module sp_mem_arbiter
    import sp_mem_arbiter_pkg::*;
#(
    parameter int DEPTH        = DEPTH_DEF,
    parameter int STARVE_LIM   = STARVE_LIM_DEF,
    parameter bit CLR_ON_RESET = 1'b1
) (
    input logic            clk,
    input logic            rst_n,
    sp_mem_arbiter_if.slave io_bus
);

    localparam int AW = $clog2(DEPTH);

    logic [0:0]    r_state;
    logic [AW-1:0] r_clr_cnt;
    owner_t        r_pend_own;
    logic          r_pend_bad;
    logic [31:0]   r_if_rdata;
    logic [31:0]   r_d_rdata;

    logic          w_run;
    logic          w_if_gnt;
    logic          w_d_gnt;
    logic          w_any_gnt;
    logic [31:0]   w_gnt_addr;
    logic          w_legal;
    logic [31:0]   w_rsp_data;
    logic          w_if_rvalid;
    logic          w_d_rvalid;

    assign w_run = (r_state == ST_RUN);

    sp_arb_prio #(
        .STARVE_LIM (STARVE_LIM)
    ) u_prio (
        .clk      (clk),
        .rst_n    (rst_n),
        .i_en     (w_run),
        .i_if_req (io_bus.if_req),
        .i_d_req  (io_bus.d_req),
        .o_if_gnt (w_if_gnt),
        .o_d_gnt  (w_d_gnt)
    );

    assign w_any_gnt  = w_if_gnt || w_d_gnt;
    assign w_gnt_addr = w_d_gnt ? io_bus.d_addr : io_bus.if_addr;
    assign w_legal    = addr_ok(w_gnt_addr, DEPTH);

    always_comb begin
        io_bus.mem_en    = 1'b1;
        io_bus.mem_we    = 1'b1;
        io_bus.mem_addr  = r_clr_cnt;
        io_bus.mem_wdata = '0;
        if (w_run) begin
            io_bus.mem_en    = w_any_gnt && w_legal;
            io_bus.mem_we    = w_any_gnt && w_legal && w_d_gnt && io_bus.d_we;
            io_bus.mem_addr  = w_gnt_addr[AW+1:2];
            io_bus.mem_wdata = io_bus.d_wdata;
        end
    end

    // A rejected read still answers, with zero data instead of the macro output.
    assign w_rsp_data  = r_pend_bad ? 32'd0 : io_bus.mem_rdata;
    assign w_if_rvalid = (r_pend_own == OWN_IF);
    assign w_d_rvalid  = (r_pend_own == OWN_D);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state    <= CLR_ON_RESET ? ST_INIT : ST_RUN;
            r_clr_cnt  <= '0;
            r_pend_own <= OWN_NONE;
            r_pend_bad <= 1'b0;
            r_if_rdata <= '0;
            r_d_rdata  <= '0;
        end else begin
            if (r_state == ST_INIT) begin
                r_clr_cnt <= r_clr_cnt + 1'b1;
                if (r_clr_cnt == AW'(DEPTH - 1)) begin
                    r_state <= ST_RUN;
                end
            end
            r_pend_bad <= w_any_gnt && !w_legal;
            if (w_if_gnt) begin
                r_pend_own <= OWN_IF;
            end else if (w_d_gnt && !io_bus.d_we) begin
                r_pend_own <= OWN_D;
            end else begin
                r_pend_own <= OWN_NONE;
            end
            if (w_if_rvalid) begin
                r_if_rdata <= w_rsp_data;
            end
            if (w_d_rvalid) begin
                r_d_rdata <= w_rsp_data;
            end
        end
    end

    assign io_bus.ready     = w_run;
    assign io_bus.if_gnt    = w_if_gnt;
    assign io_bus.d_gnt     = w_d_gnt;
    assign io_bus.if_rvalid = w_if_rvalid;
    assign io_bus.d_rvalid  = w_d_rvalid;
    assign io_bus.if_rdata  = w_if_rvalid ? w_rsp_data : r_if_rdata;
    assign io_bus.d_rdata   = w_d_rvalid ? w_rsp_data : r_d_rdata;
    assign io_bus.err       = r_pend_bad;

endmodule

// File: tb/tb_sp_mem_arbiter.sv
// Directed bench for sp_mem_arbiter with a behavioural single-port memory.
module tb_sp_mem_arbiter;

    logic clk;
    logic rst_n;
    int   n_assert;
    int   n_fail;

    sp_mem_arbiter_if #(.AW(12)) bus_if ();

    sp_mem_arbiter #(
        .DEPTH        (4096),
        .STARVE_LIM   (4),
        .CLR_ON_RESET (1'b1)
    ) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .io_bus (bus_if)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Memory macro: registered read, write on enable.
    logic [31:0] mem_model [4096];
    always @(posedge clk) begin
        if (bus_if.mem_en) begin
            if (bus_if.mem_we) mem_model[bus_if.mem_addr] <= bus_if.mem_wdata;
            else               bus_if.mem_rdata <= mem_model[bus_if.mem_addr];
        end
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_assert++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic set_d(input logic req, input logic we, input logic [31:0] addr, input logic [31:0] wdata);
        bus_if.d_req   = req;
        bus_if.d_we    = we;
        bus_if.d_addr  = addr;
        bus_if.d_wdata = wdata;
    endtask

    task automatic set_if(input logic req, input logic [31:0] addr);
        bus_if.if_req  = req;
        bus_if.if_addr = addr;
    endtask

    initial begin
        int bad_addr, bad_ctl, bad_gnt, bad_rdy;
        logic [10:0] g_if, g_d, rv_if, rv_d;
        n_assert = 0;
        n_fail   = 0;
        rst_n    = 1'b0;
        set_if(1'b0, 32'h0);
        set_d(1'b0, 1'b0, 32'h0, 32'h0);

        // Reset then the 4096-cycle clear sweep, with both ports requesting.
        next_cycle();
        rst_n = 1'b1;
        set_if(1'b1, 32'h0);
        set_d(1'b1, 1'b0, 32'h0, 32'h0);
        bad_addr = 0; bad_ctl = 0; bad_gnt = 0; bad_rdy = 0;
        for (int i = 0; i < 4096; i++) begin
            @(negedge clk);
            if (i == 0) begin
                chk("rst_if_rvalid", 32'(bus_if.if_rvalid), 32'd0);
                chk("rst_d_rvalid",  32'(bus_if.d_rvalid),  32'd0);
                chk("rst_err",       32'(bus_if.err),       32'd0);
                chk("rst_if_rdata",  bus_if.if_rdata,       32'd0);
                chk("rst_d_rdata",   bus_if.d_rdata,        32'd0);
            end
            if (bus_if.mem_addr !== 12'(i)) bad_addr++;
            if (bus_if.mem_en !== 1'b1 || bus_if.mem_we !== 1'b1 || bus_if.mem_wdata !== 32'd0) bad_ctl++;
            if (bus_if.if_gnt !== 1'b0 || bus_if.d_gnt !== 1'b0) bad_gnt++;
            if (bus_if.ready !== 1'b0) bad_rdy++;
            next_cycle();
        end
        $display("txn init sweep: 4096 cycles observed");
        chk("init_addr_bad_cycles",  32'(bad_addr), 32'd0);
        chk("init_ctl_bad_cycles",   32'(bad_ctl),  32'd0);
        chk("init_gnt_bad_cycles",   32'(bad_gnt),  32'd0);
        chk("init_ready_bad_cycles", 32'(bad_rdy),  32'd0);
        set_if(1'b0, 32'h0);
        set_d(1'b0, 1'b0, 32'h0, 32'h0);
        @(negedge clk);
        chk("ready_cycle_4097", 32'(bus_if.ready),  32'd1);
        chk("idle_mem_en",      32'(bus_if.mem_en), 32'd0);
        next_cycle();

        // Store 0x10 then load 0x10 back to back.
        set_d(1'b1, 1'b1, 32'h10, 32'hDEADBEEF);
        @(negedge clk);
        $display("txn store addr=0x10 data=0xdeadbeef");
        chk("st_d_gnt",    32'(bus_if.d_gnt),   32'd1);
        chk("st_mem_we",   32'(bus_if.mem_we),  32'd1);
        chk("st_mem_addr", 32'(bus_if.mem_addr), 32'd4);
        next_cycle();
        set_d(1'b1, 1'b0, 32'h10, 32'h0);
        @(negedge clk);
        $display("txn load addr=0x10");
        chk("ld_d_gnt",       32'(bus_if.d_gnt),    32'd1);
        chk("ld_mem_we",      32'(bus_if.mem_we),   32'd0);
        chk("st_no_d_rvalid", 32'(bus_if.d_rvalid), 32'd0);
        next_cycle();
        set_d(1'b0, 1'b0, 32'h0, 32'h0);
        @(negedge clk);
        chk("ld_d_rvalid",     32'(bus_if.d_rvalid),  32'd1);
        chk("ld_d_rdata",      bus_if.d_rdata,        32'hDEADBEEF);
        chk("ld_no_if_rvalid", 32'(bus_if.if_rvalid), 32'd0);
        next_cycle();
        @(negedge clk);
        chk("ld_rvalid_drop", 32'(bus_if.d_rvalid), 32'd0);
        chk("ld_rdata_hold",  bus_if.d_rdata,       32'hDEADBEEF);
        next_cycle();

        // Both ports held: D,D,D,D,IF repeating.
        set_if(1'b1, 32'h20);
        set_d(1'b1, 1'b0, 32'h10, 32'h0);
        for (int i = 0; i < 11; i++) begin
            @(negedge clk);
            g_if[i]  = bus_if.if_gnt;
            g_d[i]   = bus_if.d_gnt;
            rv_if[i] = bus_if.if_rvalid;
            rv_d[i]  = bus_if.d_rvalid;
            if (i == 4) chk("starve_if_mem_addr", 32'(bus_if.mem_addr), 32'd8);
            next_cycle();
            if (i == 9) begin
                set_if(1'b0, 32'h0);
                set_d(1'b0, 1'b0, 32'h0, 32'h0);
            end
        end
        $display("txn contention: if_gnt=%b d_gnt=%b", g_if, g_d);
        chk("starve_if_gnt",    32'(g_if),  32'h210);
        chk("starve_d_gnt",     32'(g_d),   32'h1EF);
        chk("starve_if_rvalid", 32'(rv_if), 32'h420);
        chk("starve_d_rvalid",  32'(rv_d),  32'h3DE);

        // Misaligned then out-of-range loads.
        set_d(1'b1, 1'b0, 32'h3, 32'h0);
        @(negedge clk);
        $display("txn load addr=0x3 (misaligned)");
        chk("mis_d_gnt",  32'(bus_if.d_gnt),  32'd1);
        chk("mis_mem_en", 32'(bus_if.mem_en), 32'd0);
        next_cycle();
        set_d(1'b1, 1'b0, 32'h4000, 32'h0);
        @(negedge clk);
        $display("txn load addr=0x4000 (out of range)");
        chk("mis_err",      32'(bus_if.err),      32'd1);
        chk("mis_d_rvalid", 32'(bus_if.d_rvalid), 32'd1);
        chk("mis_d_rdata",  bus_if.d_rdata,       32'd0);
        chk("oor_d_gnt",    32'(bus_if.d_gnt),    32'd1);
        chk("oor_mem_en",   32'(bus_if.mem_en),   32'd0);
        next_cycle();
        set_d(1'b0, 1'b0, 32'h0, 32'h0);
        @(negedge clk);
        chk("oor_err",      32'(bus_if.err),      32'd1);
        chk("oor_d_rvalid", 32'(bus_if.d_rvalid), 32'd1);
        chk("oor_d_rdata",  bus_if.d_rdata,       32'd0);
        next_cycle();
        @(negedge clk);
        chk("err_pulse_end", 32'(bus_if.err), 32'd0);
        next_cycle();

        // Fill words 0..2, then fetch them back to back.
        for (int k = 0; k < 3; k++) begin
            set_d(1'b1, 1'b1, 32'(4 * k), 32'h11111111 * 32'(k + 1));
            next_cycle();
        end
        set_d(1'b0, 1'b0, 32'h0, 32'h0);
        for (int k = 0; k < 4; k++) begin
            if (k < 3) set_if(1'b1, 32'(4 * k));
            else       set_if(1'b0, 32'h0);
            @(negedge clk);
            if (k < 3) begin
                $display("txn fetch addr=0x%0h", 4 * k);
                chk("fetch_if_gnt",   32'(bus_if.if_gnt),   32'd1);
                chk("fetch_mem_addr", 32'(bus_if.mem_addr), 32'(k));
            end
            if (k > 0) begin
                chk("fetch_if_rvalid", 32'(bus_if.if_rvalid), 32'd1);
                chk("fetch_if_rdata",  bus_if.if_rdata,       32'h11111111 * 32'(k));
                chk("fetch_no_d_rvalid", 32'(bus_if.d_rvalid), 32'd0);
            end
            next_cycle();
        end

        // Reset sampled on the edge that would launch a fetch response.
        set_if(1'b1, 32'h4);
        @(negedge clk);
        $display("txn fetch addr=0x4 with reset");
        chk("rstmid_if_gnt", 32'(bus_if.if_gnt), 32'd1);
        rst_n = 1'b0;
        next_cycle();
        rst_n = 1'b1;
        set_if(1'b0, 32'h0);
        @(negedge clk);
        chk("rstmid_if_rvalid", 32'(bus_if.if_rvalid), 32'd0);
        chk("rstmid_ready",     32'(bus_if.ready),     32'd0);
        chk("rstmid_if_rdata",  bus_if.if_rdata,       32'd0);
        chk("rstmid_mem_we",    32'(bus_if.mem_we),    32'd1);
        chk("rstmid_mem_addr0", 32'(bus_if.mem_addr),  32'd0);
        next_cycle();
        @(negedge clk);
        chk("rstmid_mem_addr1",  32'(bus_if.mem_addr),  32'd1);
        chk("rstmid_if_rvalid2", 32'(bus_if.if_rvalid), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
